acp_mem_responder: RTL and testbench



---
 rtl/acp_mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_acp_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acp_mem_responder.sv
// AXI slave memory model for the 64-bit ACP master port: independent write (AW/W/B)
// and read (AR/R) burst engines over a dual-port word-addressed RAM.
module acp_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [4:0]  S_AXI_AWUSER,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [4:0]  S_AXI_ARUSER,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int HI = DEPTH_LOG2 + 3;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [63:0] mem [1 << DEPTH_LOG2];

    logic unused_sigs;
    assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWUSER, S_AXI_ARPROT,
                           S_AXI_ARCACHE, S_AXI_ARUSER, S_AXI_AWADDR[2:0], S_AXI_ARADDR[2:0]};

    // DECERR outranks SLVERR; only the start address is decoded.
    function automatic logic [1:0] burst_resp(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        if (addr[31:HI] != BASE_ADDR[31:HI]) return 2'b11;
        if (burst[1] || size != 3'd3) return 2'b10;
        return 2'b00;
    endfunction

    w_state_e              w_state_q, w_state_d;
    logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic                  w_fixed_q, w_fixed_d, w_en;
    logic [1:0]            w_resp_q, w_resp_d;

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_resp_d  = w_resp_q;
        w_en      = 1'b0;
        case (w_state_q)
            W_IDLE: if (S_AXI_AWVALID) begin
                w_idx_d   = S_AXI_AWADDR[HI-1:3];
                w_len_d   = S_AXI_AWLEN;
                w_cnt_d   = 8'd0;
                w_fixed_d = (S_AXI_AWBURST == 2'b00);
                w_resp_d  = burst_resp(S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST);
                w_state_d = W_DATA;
            end
            W_DATA: if (S_AXI_WVALID) begin
                w_en    = (w_resp_q == 2'b00);
                w_cnt_d = w_cnt_q + 8'd1;
                if (!w_fixed_q) w_idx_d = w_idx_q + IDX_ONE;
                // A misplaced WLAST poisons the response but the beat count still ends the burst.
                if ((S_AXI_WLAST != (w_cnt_q == w_len_q)) && w_resp_q != 2'b11) w_resp_d = 2'b10;
                if (w_cnt_q == w_len_q) w_state_d = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_resp_q  <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_resp_q  <= w_resp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int b = 0; b < 8; b++)
                if (S_AXI_WSTRB[b]) mem[w_idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
    end

    assign S_AXI_AWREADY = (w_state_q == W_IDLE);
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = w_resp_q;

    r_state_e              r_state_q, r_state_d;
    logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d, ar_idx;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic                  r_fixed_q, r_fixed_d, rlast_q, rlast_d;
    logic [1:0]            r_resp_q, r_resp_d, ar_resp;
    logic [63:0]           rdata_q, rdata_d;

    assign ar_idx  = S_AXI_ARADDR[HI-1:3];
    assign ar_resp = burst_resp(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST);

    // r_idx_q always points at the next word to load; the RAM read sees pre-write data.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_fixed_d = r_fixed_q;
        r_resp_d  = r_resp_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: if (S_AXI_ARVALID) begin
                r_len_d   = S_AXI_ARLEN;
                r_cnt_d   = 8'd0;
                r_fixed_d = (S_AXI_ARBURST == 2'b00);
                r_resp_d  = ar_resp;
                rdata_d   = (ar_resp == 2'b00) ? mem[ar_idx] : 64'd0;
                rlast_d   = (S_AXI_ARLEN == 8'd0);
                r_idx_d   = (S_AXI_ARBURST == 2'b00) ? ar_idx : ar_idx + IDX_ONE;
                r_state_d = R_DATA;
            end
            R_DATA: if (S_AXI_RREADY) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    rdata_d = (r_resp_q == 2'b00) ? mem[r_idx_q] : 64'd0;
                    r_cnt_d = r_cnt_q + 8'd1;
                    rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    if (!r_fixed_q) r_idx_d = r_idx_q + IDX_ONE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_resp_q  <= 2'b00;
            rdata_q   <= 64'd0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            r_resp_q  <= r_resp_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
        end
    end

    assign S_AXI_ARREADY = (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = r_resp_q;
    assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_acp_mem_responder.sv
// Randomized bench for acp_mem_responder: transaction tasks drive AXI bursts and compare
// against a word-array model of the 8 KiB window updated from the bursts' rules.
module tb_acp_mem_responder;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [63:0] wdata = '0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_mem [1024];
    logic [63:0] wbuf_data [256];
    logic [7:0]  wbuf_strb [256];

    acp_mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWPROT(3'b000), .S_AXI_AWCACHE(4'b0011), .S_AXI_AWUSER(5'd0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARPROT(3'b000), .S_AXI_ARCACHE(4'b0011), .S_AXI_ARUSER(5'd0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_resp_of(input logic [31:0] a, input logic [2:0] sz,
                                               input logic [1:0] bu);
        if ((a >> 13) != (BASE >> 13)) return 2'b11;
        if (sz != 3'd3 || !(bu == 2'b00 || bu == 2'b01)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 3) % 1024);
    endfunction

    // Full write transaction; bad_last >= 0 puts WLAST only on that beat.
    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input int bad_last, input string name);
        logic [1:0] exp = exp_resp_of(addr, size, burst);
        logic ok = (exp == 2'b00);
        int idx = idx_of(addr);
        int t;
        if (bad_last >= 0 && exp != 2'b11) exp = 2'b10;
        @(negedge clk);
        awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL %s aw_timeout awready=%b need 1", name, awready); end
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL %s wready_latency got %b need 1", name, wready); end
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = wbuf_strb[i];
            wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
            t = 0;
            while (!wready && t < 300) begin @(negedge clk); t++; end
            checks++;
            if (wready !== 1'b1) begin errors++; $display("FAIL %s w_beat%0d_timeout wready=%b need 1", name, i, wready); end
            if (ok)
                for (int b = 0; b < 8; b++)
                    if (wbuf_strb[i][b]) model_mem[idx][8*b +: 8] = wbuf_data[i][8*b +: 8];
            if (wlast != (i == len)) ok = 1'b0;
            if (burst == 2'b01) idx = (idx + 1) % 1024;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== exp)
            begin errors++; $display("FAIL %s bresp got v=%b r=%b need v=1 r=%b", name, bvalid, bresp, exp); end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1)
            begin errors++; $display("FAIL %s b_done got bvalid=%b awready=%b need 0 1", name, bvalid, awready); end
    endtask

    // mode 0: RREADY held high, 1: pattern 1,0,0 repeating, 2: random.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int mode, input string name);
        logic [1:0]  exp = exp_resp_of(addr, size, burst);
        logic [63:0] exp_d [256];
        int idx = idx_of(addr);
        int beat, cyc, t;
        logic rr;
        for (int i = 0; i <= len; i++) begin
            exp_d[i] = (exp == 2'b00) ? model_mem[idx] : 64'd0;
            if (burst == 2'b01) idx = (idx + 1) % 1024;
        end
        @(negedge clk);
        araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL %s ar_timeout arready=%b need 1", name, arready); end
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL %s rvalid_latency got %b need 1", name, rvalid); end
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 3000) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp_d[beat] || rlast !== (beat == len) || rresp !== exp)
                begin
                    errors++;
                    $display("FAIL %s beat%0d got v=%b d=%h l=%b r=%b need v=1 d=%h l=%b r=%b", name, beat,
                             rvalid, rdata, rlast, rresp, exp_d[beat], (beat == len), exp);
                end
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom % 2);
            rready = rr;
            @(negedge clk);
            cyc++;
            if (rr) beat++;
        end
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1)
            begin errors++; $display("FAIL %s r_done got rvalid=%b arready=%b need 0 1", name, rvalid, arready); end
        if (mode == 0) begin
            checks++;
            if (cyc != len + 1) begin errors++; $display("FAIL %s throughput cycles=%0d need %0d", name, cyc, len + 1); end
        end
    endtask

    task automatic fill_wbuf(input int n, input logic [7:0] strb);
        for (int i = 0; i < n; i++) begin
            wbuf_data[i] = {$urandom, $urandom};
            wbuf_strb[i] = strb;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00 ||
            arready !== 1'b1 || rvalid !== 1'b0 || rdata !== 64'd0 || rresp !== 2'b00 || rlast !== 1'b0)
            begin
                errors++;
                $display("FAIL reset_values got aw=%b w=%b bv=%b br=%b ar=%b rv=%b rd=%h rr=%b rl=%b need 1 0 0 0 1 0 0 0 0",
                         awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast);
            end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill;
        for (int k = 0; k < 4; k++) begin
            fill_wbuf(256, 8'hFF);
            do_write(BASE + 32'(k * 2048), 255, 2'b01, 3'd3, -1, "fill");
        end
    endtask

    task automatic test_single;
        wvalid = 1'b1; wdata = 64'hDEAD_BEEF_DEAD_BEEF; wstrb = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (wready !== 1'b0) begin errors++; $display("FAIL w_before_aw wready=%b need 0", wready); end
        end
        wvalid = 1'b0;
        wbuf_data[0] = 64'h0123_4567_89AB_CDEF; wbuf_strb[0] = 8'hFF;
        do_write(32'h1000_0008, 0, 2'b01, 3'd3, -1, "single_wr");
        checks++;
        if (model_mem[1] !== 64'h0123_4567_89AB_CDEF)
            begin errors++; $display("FAIL single_model got %h need 0123456789abcdef", model_mem[1]); end
        do_read(32'h1000_0008, 0, 2'b01, 3'd3, 0, "single_rd");
    endtask

    task automatic test_incr_strobe;
        fill_wbuf(4, 8'hFF);
        wbuf_strb[2] = 8'h0F;
        do_write(32'h1000_0100, 3, 2'b01, 3'd3, -1, "incr_wr");
        do_read(32'h1000_0100, 3, 2'b01, 3'd3, 2, "incr_rd");
    endtask

    task automatic test_stall;
        do_read(32'h1000_0040, 7, 2'b01, 3'd3, 1, "stall_rd");
        do_read(32'h1000_0040, 7, 2'b01, 3'd3, 0, "b2b_rd");
        fill_wbuf(4, 8'hFF);
        do_write(32'h1000_1FF0, 3, 2'b01, 3'd3, -1, "wrap_wr");
        do_read(32'h1000_1FF0, 3, 2'b01, 3'd3, 2, "wrap_rd");
        fill_wbuf(3, 8'hFF);
        do_write(32'h1000_0300, 2, 2'b00, 3'd3, -1, "fixed_wr");
        do_read(32'h1000_0300, 2, 2'b00, 3'd3, 0, "fixed_rd");
    endtask

    task automatic test_errors;
        fill_wbuf(2, 8'hFF);
        do_write(32'h2000_0000, 1, 2'b01, 3'd3, -1, "decerr_wr");
        do_read(BASE, 1, 2'b01, 3'd3, 0, "decerr_mem");
        fill_wbuf(2, 8'hFF);
        do_write(32'h1000_0200, 1, 2'b10, 3'd3, -1, "wrap_slverr_wr");
        do_read(32'h1000_0200, 1, 2'b01, 3'd3, 0, "slverr_mem");
        do_read(32'h1000_0200, 3, 2'b01, 3'd2, 1, "size_slverr_rd");
        do_read(32'h2000_0000, 2, 2'b01, 3'd3, 0, "decerr_rd");
    endtask

    task automatic test_wlast;
        fill_wbuf(4, 8'hFF);
        do_write(32'h1000_0400, 3, 2'b01, 3'd3, 1, "early_wlast");
    endtask

    task automatic test_reset_mid_read;
        int t;
        @(negedge clk);
        araddr = 32'h1000_0100; arlen = 8'd5; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 300) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== model_mem[34])
            begin errors++; $display("FAIL rst_beat2 got v=%b d=%h need v=1 d=%h", rvalid, rdata, model_mem[34]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 64'd0 || rlast !== 1'b0 || rresp !== 2'b00 || arready !== 1'b1 ||
            awready !== 1'b1 || bvalid !== 1'b0)
            begin errors++; $display("FAIL rst_async got rv=%b rd=%h rl=%b rr=%b ar=%b need 0 0 0 0 1", rvalid, rdata, rlast, rresp, arready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b0 || arready !== 1'b1)
                begin errors++; $display("FAIL rst_no_beats got rvalid=%b arready=%b need 0 1", rvalid, arready); end
        end
        rready = 1'b0;
        do_read(32'h1000_0100, 3, 2'b01, 3'd3, 0, "post_rst_rd");
    endtask

    task automatic test_concurrent;
        fill_wbuf(256, 8'hFF);
        fork
            do_write(BASE, 255, 2'b01, 3'd3, -1, "conc_wr");
            do_read(BASE + 32'h1000, 255, 2'b01, 3'd3, 2, "conc_rd");
        join
        do_read(BASE, 255, 2'b01, 3'd3, 0, "conc_check");
    endtask

    initial begin
        test_reset;
        test_fill;
        test_single;
        test_incr_strobe;
        test_stall;
        test_errors;
        test_wlast;
        test_reset_mid_read;
        test_concurrent;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
